// File: rtl/timer.sv
// Free-running seconds timer: counts enabled clock edges and emits registered one-cycle
// pulses every half second and every full second of enabled time.
module timer #(
  parameter int unsigned TICKS_PER_SECOND = 50000000,
  parameter int unsigned HALF_TICKS       = TICKS_PER_SECOND / 2
) (
  input  logic clk,
  input  logic async_reset,
  input  logic enable,
  input  logic clear,
  output logic second_elapsed,
  output logic half_second_elapsed
);

  localparam int unsigned CntW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;

  localparam logic [CntW-1:0] CntLast     = CntW'(TICKS_PER_SECOND - 1);
  localparam logic [CntW-1:0] CntHalfLast = CntW'(HALF_TICKS - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);

  if ((TICKS_PER_SECOND < 2) || (TICKS_PER_SECOND % 2 != 0)) begin : gen_bad_ticks
    $error("timer: TICKS_PER_SECOND must be even and >= 2");
  end
  if (HALF_TICKS != TICKS_PER_SECOND / 2) begin : gen_bad_half
    $error("timer: HALF_TICKS is derived and must not be overridden");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sec_q, sec_d;
  logic            half_q, half_d;

  // Pulses are computed from the pre-increment count so they land on the edge that
  // completes the interval and are visible in the following cycle.
  always_comb begin
    cnt_d  = cnt_q;
    sec_d  = 1'b0;
    half_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CntLast) begin
        cnt_d  = '0;
        sec_d  = 1'b1;
        half_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CntOne;
        half_d = (cnt_q == CntHalfLast);
      end
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      cnt_q  <= '0;
      sec_q  <= 1'b0;
      half_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sec_q  <= sec_d;
      half_q <= half_d;
    end
  end

  assign second_elapsed      = sec_q;
  assign half_second_elapsed = half_q;

endmodule

// File: tb/tb_timer.sv
// Directed and randomized checks of timer against an elapsed-tick reference model.
`timescale 1ns / 100ps
module tb_timer;

  localparam int unsigned T = 10;
  localparam int unsigned H = T / 2;

  logic clk = 1'b0;
  logic async_reset;
  logic enable;
  logic clear;
  logic second_elapsed;
  logic half_second_elapsed;

  int checks = 0;
  int errors = 0;

  // Reference model: total enabled ticks since last clear/reset; pulses fall on multiples.
  int ticks = 0;
  bit half_m = 1'b0;
  bit sec_m  = 1'b0;

  int half_cnt;
  int sec_cnt;

  timer #(.TICKS_PER_SECOND(T)) dut (
    .clk                 (clk),
    .async_reset         (async_reset),
    .enable              (enable),
    .clear               (clear),
    .second_elapsed      (second_elapsed),
    .half_second_elapsed (half_second_elapsed)
  );

  always #1 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_half"}, int'(half_second_elapsed), int'(half_m));
    check({tag, "_sec"},  int'(second_elapsed),      int'(sec_m));
    check({tag, "_cnt"},  int'(dut.cnt_q),           ticks % T);
  endtask

  task automatic model_reset();
    ticks  = 0;
    half_m = 1'b0;
    sec_m  = 1'b0;
  endtask

  // Drive inputs, take one edge, update the model, sample half a cycle later.
  task automatic step(input logic en, input logic clr, input string tag);
    enable = en;
    clear  = clr;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else if (en) begin
      ticks++;
      half_m = (ticks % H == 0);
      sec_m  = (ticks % T == 0);
    end else begin
      half_m = 1'b0;
      sec_m  = 1'b0;
    end
    #0.5;
    check_all(tag);
    if (half_second_elapsed) half_cnt++;
    if (second_elapsed) sec_cnt++;
  endtask

  initial begin
    async_reset = 1'b1;
    enable      = 1'b0;
    clear       = 1'b0;

    // Reset and idle
    #5;
    check_all("reset");
    #0.5;
    async_reset = 1'b0;
    step(1'b0, 1'b1, "clear0");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "idle");

    // Continuous enable for 50 edges
    half_cnt = 0;
    sec_cnt  = 0;
    for (int i = 1; i <= 50; i++) begin
      step(1'b1, 1'b0, "run50");
      if (i == 5)  check("run50_first_half", int'(half_second_elapsed), 1);
      if (i == 6)  check("run50_half_width", int'(half_second_elapsed), 0);
      if (i == 10) check("run50_first_sec", int'(second_elapsed), 1);
    end
    check("run50_half_count", half_cnt, 10);
    check("run50_sec_count", sec_cnt, 5);

    // Pause and resume
    step(1'b0, 1'b1, "clear1");
    for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, "pause_a");
    half_cnt = 0;
    sec_cnt  = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "pause_lo");
    check("pause_no_pulses", half_cnt + sec_cnt, 0);
    check("pause_held_cnt", int'(dut.cnt_q), 7);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, "pause_b");
      if (i == 3) check("pause_sec_after_resume", int'(second_elapsed), 1);
    end

    // Clear at cnt=9 wins over the wrap pulse
    step(1'b0, 1'b1, "clear2");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, "to9");
    check("at9_cnt", int'(dut.cnt_q), 9);
    step(1'b1, 1'b1, "clear_at9");
    check("clear_at9_half", int'(half_second_elapsed), 0);
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, "after_clear");
    check("after_clear_half", int'(half_second_elapsed), 1);

    // Async reset between edges at cnt=7; X inputs while held
    step(1'b0, 1'b1, "clear3");
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, "to7");
    #0.3;
    async_reset = 1'b1;
    enable      = 1'bx;
    clear       = 1'bx;
    #0.2;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #0.5;
    check_all("async_rst_held");
    async_reset = 1'b0;
    step(1'b0, 1'b0, "post_rst_idle");
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, "post_rst");
      if (i == 4) check("post_rst_no_early_half", int'(half_second_elapsed), 0);
      if (i == 5) check("post_rst_half", int'(half_second_elapsed), 1);
    end

    // Randomized enable/clear traffic
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 24) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
